// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg
//   Shared constants for the seven-segment scan driver:
//   - SEG_TABLE : 16-entry active-low segment patterns {a,b,c,d,e,f,g,dp},
//                 decimal point off (bit0 = 1).
//   - SEG_OFF   : all segments dark in active-low terms.
//   - clog2     : ceiling log2, used to size the prescaler and digit index.
package seg7_scan_driver_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [7:0] SEG_TABLE [16] = '{
        8'b00000011,  // 0
        8'b10011111,  // 1
        8'b00100101,  // 2
        8'b00001101,  // 3
        8'b10011001,  // 4
        8'b01001001,  // 5
        8'b01000001,  // 6
        8'b00011111,  // 7
        8'b00000001,  // 8
        8'b00001001,  // 9
        8'b00010001,  // A
        8'b11000001,  // b
        8'b01100011,  // C
        8'b10000101,  // d
        8'b01100001,  // E
        8'b01110001   // F
    };

    // Ceiling log2; returns 0 for n <= 1, so callers clamp widths to >= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_hex_to_seg7.sv
// hex_to_seg7
//   Combinational hex nibble to active-low seven-segment pattern.
//   Ports:
//     nibble  in   4  hex digit 0..F
//     dp      in   1  decimal point, 1 = lit (clears bit0)
//     seg_n   out  8  {a,b,c,d,e,f,g,dp}, active-low
module hex_to_seg7
    import seg7_scan_driver_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    always_comb begin
        seg_n = SEG_TABLE[nibble];
        if (dp) seg_n[0] = 1'b0;
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed seven-segment driver for NUM_DIGITS hex digits on one
//   shared segment bus. A pending register captures value/dp on load; it is
//   copied into the committed (displayed) register only at frame wrap so a
//   frame never shows a mix of old and new digits. Each digit slot lasts
//   CLK_DIV clocks, the first BLANK_CYCLES of which keep every anode off so
//   segment changes never ghost onto a neighbouring digit.
//   Ports:
//     clk, rst    clock, asynchronous active-high reset
//     enable      scan enable; 0 holds the scan at digit 0 and darkens all
//     load        one-cycle strobe: value/dp are taken on any clock where
//                 load is high (no back-pressure, always accepted)
//     value, dp   packed digits (digit 0 rightmost) and decimal points
//     lz_en       leading-zero suppression enable
//     seg, an     registered segment and anode buses (polarity ACTIVE_LOW)
//     frame_tick  one-cycle pulse, one clock after the last slot ends
module seg7_scan_driver
    import seg7_scan_driver_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 2,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp,
    input  logic                      lz_en,
    output logic [7:0]                seg,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_tick
);

    localparam int PW = (CLK_DIV > 1) ? clog2(CLK_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    // Everything is built active-low / one-hot-high internally and flipped
    // by these masks on the way into the output registers.
    localparam logic [7:0] SEG_POL = (ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;
    localparam logic [NUM_DIGITS-1:0] AN_POL =
        (ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [7:0] SEG_RST = SEG_OFF ^ SEG_POL;

    logic [PW-1:0]             presc_q, presc_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [NUM_DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic [4*NUM_DIGITS-1:0]   comm_val_q, comm_val_d;
    logic [NUM_DIGITS-1:0]     comm_dp_q, comm_dp_d;
    logic [7:0]                seg_q, seg_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;
    logic                      tick_q, tick_d;

    logic                      last_slot;
    logic                      wrap;
    logic                      zero_run;
    logic [NUM_DIGITS-1:0]     lz_mask;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_supp;
    logic [NUM_DIGITS-1:0]     an_hot;
    logic [7:0]                dec_seg;

    assign last_slot = (presc_q == PRESC_LAST);
    assign wrap      = enable && last_slot && (idx_q == IDX_LAST);

    // Walk down from the top digit: a digit is suppressed while every digit
    // from it upward is a zero without a decimal point. Digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (comm_val_q[4*i +: 4] == 4'h0) & ~comm_dp_q[i];
            lz_mask[i] = zero_run & lz_en;
        end
    end

    // Select the committed digit addressed by the scan index.
    always_comb begin
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_supp = 1'b0;
        an_hot   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = comm_val_q[4*i +: 4];
                cur_dp    = comm_dp_q[i];
                cur_supp  = lz_mask[i];
                an_hot[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg_n  (dec_seg)
    );

    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp;
        end

        presc_d    = presc_q;
        idx_d      = idx_q;
        comm_val_d = comm_val_q;
        comm_dp_d  = comm_dp_q;
        seg_d      = SEG_RST;
        an_d       = AN_POL;
        tick_d     = 1'b0;

        if (!enable) begin
            // Parked at digit 0 blank phase; display tracks pending directly.
            presc_d    = '0;
            idx_d      = '0;
            comm_val_d = pend_val_q;
            comm_dp_d  = pend_dp_q;
        end else begin
            presc_d = last_slot ? '0 : presc_q + 1'b1;
            if (last_slot) begin
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end
            // Uses pending as it stood before this cycle's load, so a load
            // landing on the wrap cycle waits for the following frame.
            if (wrap) begin
                comm_val_d = pend_val_q;
                comm_dp_d  = pend_dp_q;
            end
            tick_d = wrap;
            if ((presc_q >= BLANK_END) && !cur_supp) begin
                seg_d = dec_seg ^ SEG_POL;
                an_d  = an_hot ^ AN_POL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q    <= '0;
            idx_q      <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            comm_val_q <= '0;
            comm_dp_q  <= '0;
            seg_q      <= SEG_RST;
            an_q       <= AN_POL;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            comm_val_q <= comm_val_d;
            comm_dp_q  <= comm_dp_d;
            seg_q      <= seg_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Bench for seg7_scan_driver: a 4-digit active-low instance and an 8-digit
//   active-high instance, both CLK_DIV=4, BLANK_CYCLES=1. Expected per-clock
//   {care_seg, an, seg} entries for whole frames go into exp_q and are popped
//   one per clock while the frame is displayed.
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 4;
    localparam int BLANK   = 1;

    localparam logic [7:0] REF_SEG [16] = '{
        8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
        8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
        8'b00000001, 8'b00001001, 8'b00010001, 8'b11000001,
        8'b01100011, 8'b10000101, 8'b01100001, 8'b01110001
    };

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        load;
    logic        lz_en;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic        frame_tick;

    logic        load8;
    logic [31:0] value8;
    logic [7:0]  dp8;
    logic [7:0]  seg8;
    logic [7:0]  an8;
    logic        tick8;

    logic [16:0] exp_q[$];
    int          n_cmp = 0;
    int          n_mis = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

    seg7_scan_driver #(
        .NUM_DIGITS(4), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(1)
    ) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load),
        .value(value), .dp(dp), .lz_en(lz_en),
        .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(8), .CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK), .ACTIVE_LOW(0)
    ) u_dut8 (
        .clk(clk), .rst(rst), .enable(enable), .load(load8),
        .value(value8), .dp(dp8), .lz_en(lz_en),
        .seg(seg8), .an(an8), .frame_tick(tick8)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Push one full frame of expected per-clock outputs.
    task automatic push_frame(input logic [31:0] v, input logic [7:0] d,
                              input int nd, input bit lz, input bit al);
        logic [7:0] mask, off, hot, an_v, pat, seg_v;
        bit         supp;
        mask = 8'((32'd1 << nd) - 1);
        off  = al ? mask : 8'h00;
        for (int i = 0; i < nd; i++) begin
            for (int k = 0; k < BLANK; k++) exp_q.push_back({1'b0, off, 8'h00});
            supp = 1'b0;
            if (lz && i > 0) begin
                supp = 1'b1;
                for (int j = i; j < nd; j++)
                    if (v[4*j +: 4] != 4'h0 || d[j]) supp = 1'b0;
            end
            pat = REF_SEG[v[4*i +: 4]];
            if (d[i]) pat[0] = 1'b0;
            seg_v = al ? pat : ~pat;
            hot   = 8'(32'd1 << i);
            an_v  = al ? (mask & ~hot) : hot;
            for (int k = BLANK; k < CLK_DIV; k++) begin
                if (supp) exp_q.push_back({1'b0, off, 8'h00});
                else      exp_q.push_back({1'b1, an_v, seg_v});
            end
        end
    endtask

    // Starts at the negedge where frame_tick is seen; consumes one frame and
    // ends on the negedge where the next frame_tick must be high.
    task automatic capture_frame(input bit wide, input int nd);
        logic [16:0] e;
        logic [7:0]  a, s;
        logic        t;
        for (int k = 0; k < nd * CLK_DIV; k++) begin
            @(negedge clk);
            if (wide) begin a = an8; s = seg8; end
            else      begin a = {4'h0, an}; s = seg; end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 17'h1FFFF;
            check_eq($sformatf("%s k=%0d", wide ? "slot8" : "slot4", k),
                     {15'b0, e[16], a, (e[16] ? s : 8'h00)}, {15'b0, e});
        end
        t = wide ? tick8 : frame_tick;
        check_eq(wide ? "frame_tick8" : "frame_tick", {31'b0, t}, 32'd1);
    endtask

    task automatic wait_tick(input bit wide);
        logic t;
        t = wide ? tick8 : frame_tick;
        for (int n = 0; n < 64 && t !== 1'b1; n++) begin
            @(negedge clk);
            t = wide ? tick8 : frame_tick;
        end
        check_eq("tick_wait", {31'b0, t}, 32'd1);
    endtask

    // ---------------- driver tasks ----------------
    task automatic load_at(input int delay, input logic [15:0] v, input logic [3:0] d);
        repeat (delay) @(negedge clk);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; enable = 1'b1; load = 1'b0; lz_en = 1'b0;
        value = '0; dp = '0; load8 = 1'b0; value8 = '0; dp8 = '0;
        repeat (2) @(negedge clk);
        check_eq("rst_seg",  seg, 8'hFF);
        check_eq("rst_an",   an, 4'hF);
        check_eq("rst_tick", frame_tick, 0);
        check_eq("rst_seg8", seg8, 8'h00);
        check_eq("rst_an8",  an8, 8'h00);

        // Release; first slot is blank, digit 0 lights at clock BLANK+1.
        rst = 1'b0; value = 16'h12AB; dp = 4'h0; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check_eq("first_blank_an", an, 4'hF);
        @(negedge clk);
        check_eq("first_lit", {an, seg}, {4'hE, 8'b00000011});

        wait_tick(1'b0);
        push_frame(32'h12AB, 8'h00, 4, 1'b0, 1'b1);
        capture_frame(1'b0, 4);

        // Mid-frame load: current frame keeps old digits.
        push_frame(32'h12AB, 8'h00, 4, 1'b0, 1'b1);
        push_frame(32'h5555, 8'h00, 4, 1'b0, 1'b1);
        fork
            capture_frame(1'b0, 4);
            load_at(6, 16'h5555, 4'h0);
        join
        capture_frame(1'b0, 4);

        // Load on the wrap cycle is delayed by one extra frame.
        push_frame(32'h5555, 8'h00, 4, 1'b0, 1'b1);
        push_frame(32'h5555, 8'h00, 4, 1'b0, 1'b1);
        push_frame(32'h3C7E, 8'h00, 4, 1'b0, 1'b1);
        fork
            capture_frame(1'b0, 4);
            load_at(15, 16'h3C7E, 4'h0);
        join
        capture_frame(1'b0, 4);
        capture_frame(1'b0, 4);

        // Leading-zero suppression, then a dp on the top digit.
        lz_en = 1'b1;
        push_frame(32'h3C7E, 8'h00, 4, 1'b1, 1'b1);
        push_frame(32'h0030, 8'h00, 4, 1'b1, 1'b1);
        fork
            capture_frame(1'b0, 4);
            load_at(0, 16'h0030, 4'h0);
        join
        capture_frame(1'b0, 4);
        push_frame(32'h0030, 8'h00, 4, 1'b1, 1'b1);
        push_frame(32'h0030, 8'h08, 4, 1'b1, 1'b1);
        fork
            capture_frame(1'b0, 4);
            load_at(0, 16'h0030, 4'b1000);
        join
        capture_frame(1'b0, 4);

        // Enable dropped mid-slot, pending loaded while dark, re-enabled.
        repeat (2) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check_eq("dis_an",   an, 4'hF);
        check_eq("dis_seg",  seg, 8'hFF);
        check_eq("dis_tick", frame_tick, 0);
        load_at(0, 16'h0009, 4'h0);
        @(negedge clk);
        check_eq("dis_an2",  an, 4'hF);
        enable = 1'b1;
        push_frame(32'h0009, 8'h00, 4, 1'b1, 1'b1);
        capture_frame(1'b0, 4);

        // Asynchronous reset between edges; pending data is lost.
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_seg",  seg, 8'hFF);
        check_eq("arst_an",   an, 4'hF);
        check_eq("arst_tick", frame_tick, 0);
        check_eq("arst_seg8", seg8, 8'h00);
        check_eq("arst_an8",  an8, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        push_frame(32'h0000, 8'h00, 4, 1'b1, 1'b1);
        push_frame(32'h0000, 8'h00, 4, 1'b1, 1'b1);
        fork
            begin
                capture_frame(1'b0, 4);
                capture_frame(1'b0, 4);
            end
            begin
                value8 = 32'hFEDCBA98;
                dp8    = 8'h00;
                load8  = 1'b1;
                @(negedge clk);
                load8  = 1'b0;
            end
        join

        // 8-digit active-high instance.
        wait_tick(1'b1);
        push_frame(32'hFEDCBA98, 8'h00, 8, 1'b1, 1'b0);
        capture_frame(1'b1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
